// File: rtl/wb_sdr_arb_pkg.sv
// Shared types and constants for the two-master SDRAM Wishbone arbiter.
package wb_sdr_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GNT0,
        ARB_GNT1
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/wb_sdr_arb2_if.sv
// Bus bundle for wb_sdr_arb2: both master ports, the SDRAM-side slave port and the grant vector.
interface wb_sdr_arb2_if #(
    parameter int dw = 32,
    parameter int aw = 26
);
    logic            m0_wb_cyc_i, m1_wb_cyc_i;
    logic            m0_wb_stb_i, m1_wb_stb_i;
    logic            m0_wb_we_i,  m1_wb_we_i;
    logic [aw-1:0]   m0_wb_addr_i, m1_wb_addr_i;
    logic [dw-1:0]   m0_wb_dat_i,  m1_wb_dat_i;
    logic [dw/8-1:0] m0_wb_sel_i,  m1_wb_sel_i;
    logic [2:0]      m0_wb_cti_i,  m1_wb_cti_i;
    logic            m0_wb_ack_o,  m1_wb_ack_o;
    logic [dw-1:0]   m0_wb_dat_o,  m1_wb_dat_o;

    logic            s_wb_cyc_o, s_wb_stb_o, s_wb_we_o;
    logic [aw-1:0]   s_wb_addr_o;
    logic [dw-1:0]   s_wb_dat_o;
    logic [dw/8-1:0] s_wb_sel_o;
    logic [2:0]      s_wb_cti_o;
    logic            s_wb_ack_i;
    logic [dw-1:0]   s_wb_dat_i;

    logic [1:0]      gnt_o;

    // The arbiter's view: it is the slave of both masters.
    modport slave (
        input  m0_wb_cyc_i, m1_wb_cyc_i, m0_wb_stb_i, m1_wb_stb_i,
               m0_wb_we_i, m1_wb_we_i, m0_wb_addr_i, m1_wb_addr_i,
               m0_wb_dat_i, m1_wb_dat_i, m0_wb_sel_i, m1_wb_sel_i,
               m0_wb_cti_i, m1_wb_cti_i, s_wb_ack_i, s_wb_dat_i,
        output m0_wb_ack_o, m1_wb_ack_o, m0_wb_dat_o, m1_wb_dat_o,
               s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_addr_o,
               s_wb_dat_o, s_wb_sel_o, s_wb_cti_o, gnt_o
    );

    modport master (
        output m0_wb_cyc_i, m1_wb_cyc_i, m0_wb_stb_i, m1_wb_stb_i,
               m0_wb_we_i, m1_wb_we_i, m0_wb_addr_i, m1_wb_addr_i,
               m0_wb_dat_i, m1_wb_dat_i, m0_wb_sel_i, m1_wb_sel_i,
               m0_wb_cti_i, m1_wb_cti_i, s_wb_ack_i, s_wb_dat_i,
        input  m0_wb_ack_o, m1_wb_ack_o, m0_wb_dat_o, m1_wb_dat_o,
               s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_addr_o,
               s_wb_dat_o, s_wb_sel_o, s_wb_cti_o, gnt_o
    );
endinterface

// File: rtl/wb_sdr_arb_cnt.sv
// Saturating transfer counter: counts accepted acks, sticks at all-ones.
module wb_sdr_arb_cnt
    import wb_sdr_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/wb_sdr_arb2.sv
// Round-robin two-master Wishbone arbiter with whole-cycle ownership in front of the SDRAM controller.
// Optional per-master ack counters are built when WB_ARB_PERF_EN is defined.
module wb_sdr_arb2
    import wb_sdr_arb_pkg::*;
#(
    parameter int dw = 32,
    parameter int aw = 26
) (
    input  logic             sys_clk,
    input  logic             RESET,
    input  logic             sdr_init_done,
    wb_sdr_arb2_if.slave     bus
`ifdef WB_ARB_PERF_EN
   ,output logic [CNT_W-1:0] m0_xfer_cnt_o,
    output logic [CNT_W-1:0] m1_xfer_cnt_o
`endif
);

    arb_state_t      state;
    logic            last;
    logic [1:0]      gnt_q;
    logic            req0, req1;
    logic            ack0, ack1;

    logic            cyc_mux, stb_mux, we_mux;
    logic [aw-1:0]   addr_mux;
    logic [dw-1:0]   dat_mux;
    logic [dw/8-1:0] sel_mux;
    logic [2:0]      cti_mux;

    assign req0 = bus.m0_wb_cyc_i & bus.m0_wb_stb_i;
    assign req1 = bus.m1_wb_cyc_i & bus.m1_wb_stb_i;

    // last = 1 means m1 owned the bus most recently, so m0 wins a tie.
    always_ff @(posedge sys_clk or posedge RESET) begin
        if (RESET) begin
            state <= ARB_IDLE;
            last  <= 1'b1;
            gnt_q <= 2'b00;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (sdr_init_done) begin
                        if (req0 && (!req1 || last)) begin
                            state <= ARB_GNT0;
                            gnt_q <= 2'b01;
                        end else if (req1) begin
                            state <= ARB_GNT1;
                            gnt_q <= 2'b10;
                        end
                    end
                end
                ARB_GNT0: begin
                    if (!bus.m0_wb_cyc_i) begin
                        state <= ARB_IDLE;
                        last  <= 1'b0;
                        gnt_q <= 2'b00;
                    end
                end
                ARB_GNT1: begin
                    if (!bus.m1_wb_cyc_i) begin
                        state <= ARB_IDLE;
                        last  <= 1'b1;
                        gnt_q <= 2'b00;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    gnt_q <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        cyc_mux  = 1'b0;
        stb_mux  = 1'b0;
        we_mux   = 1'b0;
        addr_mux = '0;
        dat_mux  = '0;
        sel_mux  = '0;
        cti_mux  = '0;
        case (state)
            ARB_GNT0: begin
                cyc_mux  = bus.m0_wb_cyc_i;
                stb_mux  = bus.m0_wb_stb_i;
                we_mux   = bus.m0_wb_we_i;
                addr_mux = bus.m0_wb_addr_i;
                dat_mux  = bus.m0_wb_dat_i;
                sel_mux  = bus.m0_wb_sel_i;
                cti_mux  = bus.m0_wb_cti_i;
            end
            ARB_GNT1: begin
                cyc_mux  = bus.m1_wb_cyc_i;
                stb_mux  = bus.m1_wb_stb_i;
                we_mux   = bus.m1_wb_we_i;
                addr_mux = bus.m1_wb_addr_i;
                dat_mux  = bus.m1_wb_dat_i;
                sel_mux  = bus.m1_wb_sel_i;
                cti_mux  = bus.m1_wb_cti_i;
            end
            default: ;
        endcase
    end

    assign ack0 = (state == ARB_GNT0) & bus.s_wb_ack_i;
    assign ack1 = (state == ARB_GNT1) & bus.s_wb_ack_i;

    assign bus.s_wb_cyc_o  = cyc_mux;
    assign bus.s_wb_stb_o  = stb_mux;
    assign bus.s_wb_we_o   = we_mux;
    assign bus.s_wb_addr_o = addr_mux;
    assign bus.s_wb_dat_o  = dat_mux;
    assign bus.s_wb_sel_o  = sel_mux;
    assign bus.s_wb_cti_o  = cti_mux;
    assign bus.m0_wb_ack_o = ack0;
    assign bus.m1_wb_ack_o = ack1;
    assign bus.m0_wb_dat_o = bus.s_wb_dat_i;
    assign bus.m1_wb_dat_o = bus.s_wb_dat_i;
    assign bus.gnt_o       = gnt_q;

`ifdef WB_ARB_PERF_EN
    wb_sdr_arb_cnt u_cnt0 (
        .clk (sys_clk),
        .rst (RESET),
        .inc (ack0),
        .cnt (m0_xfer_cnt_o)
    );

    wb_sdr_arb_cnt u_cnt1 (
        .clk (sys_clk),
        .rst (RESET),
        .inc (ack1),
        .cnt (m1_xfer_cnt_o)
    );
`endif

endmodule

// File: tb/tb_wb_sdr_arb2.sv
// Directed self-checking bench for wb_sdr_arb2; the counter section runs when WB_ARB_PERF_EN is defined.
module tb_wb_sdr_arb2;
    import wb_sdr_arb_pkg::*;

    logic sys_clk = 1'b0;
    logic RESET;
    logic sdr_init_done;
    int   n_checks = 0;
    int   n_errors = 0;

    wb_sdr_arb2_if #(.dw(32), .aw(26)) bus ();

`ifdef WB_ARB_PERF_EN
    logic [CNT_W-1:0] m0_xfer_cnt_o, m1_xfer_cnt_o;
`endif

    wb_sdr_arb2 #(.dw(32), .aw(26)) dut (
        .sys_clk       (sys_clk),
        .RESET         (RESET),
        .sdr_init_done (sdr_init_done),
        .bus           (bus)
`ifdef WB_ARB_PERF_EN
       ,.m0_xfer_cnt_o (m0_xfer_cnt_o),
        .m1_xfer_cnt_o (m1_xfer_cnt_o)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive_m0(input logic cyc, input logic we, input logic [25:0] addr,
                            input logic [31:0] dat, input logic [2:0] cti);
        bus.m0_wb_cyc_i  = cyc;
        bus.m0_wb_stb_i  = cyc;
        bus.m0_wb_we_i   = we;
        bus.m0_wb_addr_i = addr;
        bus.m0_wb_dat_i  = dat;
        bus.m0_wb_sel_i  = 4'hF;
        bus.m0_wb_cti_i  = cti;
    endtask

    task automatic drive_m1(input logic cyc, input logic we, input logic [25:0] addr,
                            input logic [31:0] dat, input logic [2:0] cti);
        bus.m1_wb_cyc_i  = cyc;
        bus.m1_wb_stb_i  = cyc;
        bus.m1_wb_we_i   = we;
        bus.m1_wb_addr_i = addr;
        bus.m1_wb_dat_i  = dat;
        bus.m1_wb_sel_i  = 4'h3;
        bus.m1_wb_cti_i  = cti;
    endtask

    logic [25:0] beat_addr [4] = '{26'h100, 26'h104, 26'h108, 26'h10C};
    logic [2:0]  beat_cti  [4] = '{CTI_INCR, CTI_INCR, CTI_INCR, CTI_EOB};

    initial begin
        RESET         = 1'b1;
        sdr_init_done = 1'b0;
        drive_m0(1'b0, 1'b0, '0, '0, CTI_CLASSIC);
        drive_m1(1'b0, 1'b0, '0, '0, CTI_CLASSIC);
        bus.s_wb_ack_i = 1'b0;
        bus.s_wb_dat_i = 32'h12345678;
        #2;
        check_eq("rst_gnt",    bus.gnt_o,       2'b00);
        check_eq("rst_cyc",    bus.s_wb_cyc_o,  1'b0);
        check_eq("rst_stb",    bus.s_wb_stb_o,  1'b0);
        check_eq("rst_addr",   bus.s_wb_addr_o, 26'h0);
        check_eq("rst_m0_ack", bus.m0_wb_ack_o, 1'b0);
        check_eq("rst_m1_dat", bus.m1_wb_dat_o, 32'h12345678);

        // Request during reset and before init: nothing must reach the slave.
        drive_m0(1'b1, 1'b0, 26'h40, 32'h0, CTI_CLASSIC);
        #1;
        check_eq("rst_req_cyc", bus.s_wb_cyc_o, 1'b0);
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("init_hold_gnt", bus.gnt_o,      2'b00);
            check_eq("init_hold_cyc", bus.s_wb_cyc_o, 1'b0);
        end
        sdr_init_done = 1'b1;
        tick();
        check_eq("init_gnt",  bus.gnt_o,       2'b01);
        check_eq("init_cyc",  bus.s_wb_cyc_o,  1'b1);
        check_eq("init_addr", bus.s_wb_addr_o, 26'h40);

        // init_done falls mid-grant: owner keeps the bus, new grants wait.
        sdr_init_done = 1'b0;
        tick();
        tick();
        check_eq("initdrop_keep", bus.gnt_o, 2'b01);
        drive_m0(1'b0, 1'b0, '0, '0, CTI_CLASSIC);
        tick();
        check_eq("initdrop_rel", bus.gnt_o, 2'b00);
        drive_m0(1'b1, 1'b0, 26'h44, 32'h0, CTI_CLASSIC);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("initdrop_hold", bus.gnt_o, 2'b00);
        end
        sdr_init_done = 1'b1;
        tick();
        check_eq("initrise_gnt", bus.gnt_o, 2'b01);
        drive_m0(1'b0, 1'b0, '0, '0, CTI_CLASSIC);
        tick();
        check_eq("m0_rel_gnt", bus.gnt_o, 2'b00);

        // last = m0 now, so a tie goes to m1. m1 reads 0x2000.
        drive_m0(1'b1, 1'b1, 26'h300, 32'h0, CTI_CLASSIC);
        drive_m1(1'b1, 1'b0, 26'h2000, 32'h0, CTI_CLASSIC);
        tick();
        check_eq("tie_m1_gnt", bus.gnt_o,       2'b10);
        check_eq("m1_rd_addr", bus.s_wb_addr_o, 26'h2000);
        check_eq("m1_rd_we",   bus.s_wb_we_o,   1'b0);
        check_eq("m1_rd_sel",  bus.s_wb_sel_o,  4'h3);
        bus.s_wb_ack_i = 1'b1;
        bus.s_wb_dat_i = 32'hDEADBEEF;
        #1;
        check_eq("m1_rd_ack",  bus.m1_wb_ack_o, 1'b1);
        check_eq("m1_rd_dat",  bus.m1_wb_dat_o, 32'hDEADBEEF);
        check_eq("m1_rd_m0ack", bus.m0_wb_ack_o, 1'b0);
        check_eq("m0_bcast_dat", bus.m0_wb_dat_o, 32'hDEADBEEF);
        tick();
        // Release with an ack in the same cycle still returns to idle.
        drive_m1(1'b0, 1'b0, '0, '0, CTI_CLASSIC);
        #1;
        check_eq("m1_rel_cyc", bus.s_wb_cyc_o, 1'b0);
        tick();
        check_eq("m1_rel_gnt", bus.gnt_o, 2'b00);
        bus.s_wb_ack_i = 1'b0;

        // Tie again with last = m1: m0 owns a 4-beat write burst while m1 waits.
        drive_m1(1'b1, 1'b0, 26'h2000, 32'h0, CTI_CLASSIC);
        tick();
        check_eq("tie_m0_gnt", bus.gnt_o, 2'b01);
        for (int i = 0; i < 4; i++) begin
            drive_m0(1'b1, 1'b1, beat_addr[i], 32'hA000_0000 + 32'(i), beat_cti[i]);
            bus.s_wb_ack_i = 1'b1;
            #1;
            check_eq("burst_addr",  bus.s_wb_addr_o, beat_addr[i]);
            check_eq("burst_cti",   bus.s_wb_cti_o,  beat_cti[i]);
            check_eq("burst_dat",   bus.s_wb_dat_o,  32'hA000_0000 + 32'(i));
            check_eq("burst_we",    bus.s_wb_we_o,   1'b1);
            check_eq("burst_m0ack", bus.m0_wb_ack_o, 1'b1);
            check_eq("burst_m1ack", bus.m1_wb_ack_o, 1'b0);
            check_eq("burst_gnt",   bus.gnt_o,       2'b01);
            tick();
        end
        drive_m0(1'b0, 1'b0, '0, '0, CTI_CLASSIC);
        bus.s_wb_ack_i = 1'b0;
        tick();
        check_eq("dead_gnt",   bus.gnt_o,      2'b00);
        check_eq("dead_cyc",   bus.s_wb_cyc_o, 1'b0);
        tick();
        check_eq("m1_wait_gnt",  bus.gnt_o,       2'b10);
        check_eq("m1_wait_addr", bus.s_wb_addr_o, 26'h2000);
        drive_m1(1'b0, 1'b0, '0, '0, CTI_CLASSIC);
        tick();
        check_eq("m1_rel2_gnt", bus.gnt_o, 2'b00);

        // Reset at beat 2 of a burst, both masters requesting (last = m1 here).
        drive_m0(1'b1, 1'b1, beat_addr[0], 32'h0, beat_cti[0]);
        drive_m1(1'b1, 1'b0, 26'h2000, 32'h0, CTI_CLASSIC);
        tick();
        check_eq("rb_gnt", bus.gnt_o, 2'b01);
        bus.s_wb_ack_i = 1'b1;
        tick();
        drive_m0(1'b1, 1'b1, beat_addr[1], 32'h0, beat_cti[1]);
        RESET = 1'b1;
        #1;
        check_eq("rb_rst_gnt",   bus.gnt_o,       2'b00);
        check_eq("rb_rst_cyc",   bus.s_wb_cyc_o,  1'b0);
        check_eq("rb_rst_m0ack", bus.m0_wb_ack_o, 1'b0);
        check_eq("rb_rst_addr",  bus.s_wb_addr_o, 26'h0);
        tick();
        RESET = 1'b0;
        bus.s_wb_ack_i = 1'b0;
        tick();
        check_eq("rb_tie_gnt",  bus.gnt_o,       2'b01);
        check_eq("rb_tie_addr", bus.s_wb_addr_o, beat_addr[1]);
        drive_m0(1'b0, 1'b0, '0, '0, CTI_CLASSIC);
        tick();
        tick();
        check_eq("rb_m1_gnt", bus.gnt_o, 2'b10);
        drive_m1(1'b0, 1'b0, '0, '0, CTI_CLASSIC);
        tick();

`ifdef WB_ARB_PERF_EN
        RESET = 1'b1;
        #1;
        check_eq("cnt_rst0", m0_xfer_cnt_o, 16'h0);
        tick();
        RESET = 1'b0;
        drive_m0(1'b1, 1'b0, 26'h500, 32'h0, CTI_INCR);
        tick();
        bus.s_wb_ack_i = 1'b1;
        for (int i = 0; i < 70000; i++) tick();
        bus.s_wb_ack_i = 1'b0;
        check_eq("cnt_m0_sat", m0_xfer_cnt_o, 16'hFFFF);
        drive_m0(1'b0, 1'b0, '0, '0, CTI_CLASSIC);
        drive_m1(1'b1, 1'b0, 26'h600, 32'h0, CTI_CLASSIC);
        tick();
        tick();
        bus.s_wb_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bus.s_wb_ack_i = 1'b0;
        check_eq("cnt_m1", m1_xfer_cnt_o, 16'd3);
        check_eq("cnt_m0_hold", m0_xfer_cnt_o, 16'hFFFF);
        drive_m1(1'b0, 1'b0, '0, '0, CTI_CLASSIC);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
